// File: rtl/io_link_pattern_tester.sv
// io_link_pattern_tester
// Transmit-pattern generator and receive checker for one inter-FPGA IO link.
// The generator cycles the 7-word test sequence onto tx_data. The checker
// registers rx_data, hunts for the first sequence word, then compares every
// word and keeps error pulses, a sticky error-bit mask and saturating counters.
`timescale 1ns/1ps
module io_link_pattern_tester #(
    parameter int WIDTH       = 71,
    parameter int CNT_W       = 16,
    parameter int LOSS_THRESH = 4,
    parameter int LOST_W      = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              en,
    input  logic              clr,
    output logic [WIDTH-1:0]  tx_data,
    input  logic [WIDTH-1:0]  rx_data,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [WIDTH-1:0]  err_bits,
    output logic [LOST_W-1:0] lost_cnt
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [15:0] PAT6_WORD = 16'hF5A0;
    localparam logic [7:0]  LOSS_LIM  = 8'(LOSS_THRESH);

    // Sequence word k: bytes AA,55,0F,F0,00,FF replicated LSB-first, then F5A0.
    function automatic logic [WIDTH-1:0] pat(input logic [2:0] k);
        logic [7:0]       b;
        logic [WIDTH-1:0] w;
        case (k)
            3'd0:    b = 8'hAA;
            3'd1:    b = 8'h55;
            3'd2:    b = 8'h0F;
            3'd3:    b = 8'hF0;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'hFF;
            default: b = 8'h00;
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            w[i] = (k == 3'd6) ? PAT6_WORD[i % 16] : b[i % 8];
        end
        return w;
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] k);
        return (k == 3'd6) ? 3'd0 : k + 3'd1;
    endfunction

    logic [WIDTH-1:0]  tx_data_q, tx_data_d;
    logic [2:0]        tx_idx_q, tx_idx_d;
    logic [WIDTH-1:0]  rx_q;
    state_e            state_q, state_d;
    logic [2:0]        exp_idx_q, exp_idx_d;
    logic [7:0]        miss_run_q, miss_run_d;
    logic              err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]  err_bits_q, err_bits_d;
    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [WIDTH-1:0]  diff;

    // Generator next state: advance through the sequence only while enabled.
    always_comb begin
        tx_data_d = tx_data_q;
        tx_idx_d  = tx_idx_q;
        if (en) begin
            tx_data_d = pat(tx_idx_q);
            tx_idx_d  = next_idx(tx_idx_q);
        end
    end

    // Checker next state: hunt for the first word, then check every word.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        exp_idx_d   = exp_idx_q;
        miss_run_d  = miss_run_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_bits_d  = err_bits_q;
        lost_cnt_d  = lost_cnt_q;
        diff        = rx_q ^ pat(exp_idx_q);

        case (state_q)
            HUNT: begin
                if (rx_q == pat(3'd0)) begin
                    state_d    = LOCKED;
                    exp_idx_d  = 3'd1;
                    miss_run_d = 8'd0;
                end
            end
            LOCKED: begin
                exp_idx_d = next_idx(exp_idx_q);
                if (diff != '0) begin
                    err_pulse_d = 1'b1;
                    if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
                    err_bits_d = err_bits_q | diff;
                    miss_run_d = miss_run_q + 8'd1;
                    if (miss_run_q + 8'd1 == LOSS_LIM) begin
                        state_d = HUNT;
                        if (!(&lost_cnt_q)) lost_cnt_d = lost_cnt_q + LOST_W'(1);
                    end
                end else begin
                    miss_run_d = 8'd0;
                end
            end
            default: state_d = HUNT;
        endcase

        // clr wins over any same-cycle count update; checker state is untouched.
        if (clr) begin
            err_cnt_d  = '0;
            err_bits_d = '0;
            lost_cnt_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!RST_N) begin
            tx_data_q   <= '0;
            tx_idx_q    <= '0;
            rx_q        <= '0;
            state_q     <= HUNT;
            exp_idx_q   <= '0;
            miss_run_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            err_bits_q  <= '0;
            lost_cnt_q  <= '0;
        end else begin
            tx_data_q   <= tx_data_d;
            tx_idx_q    <= tx_idx_d;
            rx_q        <= rx_data;
            state_q     <= state_d;
            exp_idx_q   <= exp_idx_d;
            miss_run_q  <= miss_run_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            err_bits_q  <= err_bits_d;
            lost_cnt_q  <= lost_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign err_bits  = err_bits_q;
    assign lost_cnt  = lost_cnt_q;

endmodule

// File: tb/tb_io_link_pattern_tester.sv
// Bench for io_link_pattern_tester: a 71-bit link in loopback with error
// injection, plus an 8-bit instance with a 3-bit error counter for saturation.
// Stimulus pushes expected values tagged with a cycle number; a monitor on
// the falling edge checks every entry due in that cycle.
`timescale 1ns/1ps
module tb_io_link_pattern_tester;

    localparam int W = 71;

    typedef enum int {
        S_TX, S_LOCK, S_PULSE, S_CNT, S_BITS, S_LOST,
        S_CNT2, S_LOCK2, S_PULSE2, S_BITS2, S_LOST2
    } sel_e;

    typedef struct {
        int           at;
        sel_e         sel;
        logic [127:0] exp;
        string        name;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST_N, en, clr;
    logic [W-1:0]  tx_data, rx_data, err_bits, inj;
    logic          locked, err_pulse, force0;
    logic [15:0]   err_cnt;
    logic [7:0]    lost_cnt;

    logic [7:0]    tx2, rx2, bits2, inj2, lost2;
    logic          lock2, pulse2;
    logic [2:0]    cnt2;
    logic          en2  = 1'b1;
    logic          clr2 = 1'b0;

    exp_t          exp_q[$];
    int            cyc   = 0;
    int            total = 0;
    int            bad   = 0;
    int            tx_base = 0;
    logic [127:0]  act;

    assign rx_data = force0 ? '0 : (tx_data ^ inj);
    assign rx2     = tx2 ^ inj2;

    io_link_pattern_tester #(.WIDTH(W), .CNT_W(16), .LOSS_THRESH(4), .LOST_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .en(en), .clr(clr),
        .tx_data(tx_data), .rx_data(rx_data), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .err_bits(err_bits), .lost_cnt(lost_cnt)
    );

    io_link_pattern_tester #(.WIDTH(8), .CNT_W(3), .LOSS_THRESH(4), .LOST_W(8)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .en(en2), .clr(clr2),
        .tx_data(tx2), .rx_data(rx2), .locked(lock2), .err_pulse(pulse2),
        .err_cnt(cnt2), .err_bits(bits2), .lost_cnt(lost2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Expected 71-bit sequence words, written out as replicated constants.
    function automatic logic [127:0] p(input int k);
        logic [79:0] v;
        case (k)
            0: v = {10{8'hAA}};
            1: v = {10{8'h55}};
            2: v = {10{8'h0F}};
            3: v = {10{8'hF0}};
            4: v = {10{8'h00}};
            5: v = {10{8'hFF}};
            default: v = {5{16'hF5A0}};
        endcase
        return {57'd0, v[70:0]};
    endfunction

    function automatic logic [127:0] actual(input sel_e s);
        case (s)
            S_TX:     return {57'd0, tx_data};
            S_LOCK:   return {127'd0, locked};
            S_PULSE:  return {127'd0, err_pulse};
            S_CNT:    return {112'd0, err_cnt};
            S_BITS:   return {57'd0, err_bits};
            S_LOST:   return {120'd0, lost_cnt};
            S_CNT2:   return {125'd0, cnt2};
            S_LOCK2:  return {127'd0, lock2};
            S_PULSE2: return {127'd0, pulse2};
            S_BITS2:  return {120'd0, bits2};
            default:  return {120'd0, lost2};
        endcase
    endfunction

    task automatic push(input int at, input sel_e s, input logic [127:0] v, input string nm);
        exp_t e;
        e.at = at; e.sel = s; e.exp = v; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [127:0] got, input logic [127:0] want, input string nm);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Index of the sequence word tx_data currently shows (valid while en = 1).
    function automatic int ph();
        return (cyc - tx_base) % 7;
    endfunction

    task automatic wait_ph(input int k);
        for (int n = 0; n < 8 && ph() != k; n++) step();
    endtask

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge CLK) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at == cyc) begin
                act = actual(exp_q[i].sel);
                total++;
                if (act !== exp_q[i].exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", exp_q[i].name, cyc, act, exp_q[i].exp);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        int f;
        RST_N = 1'b0; en = 1'b0; clr = 1'b0; inj = '0; force0 = 1'b0; inj2 = '0;
        repeat (3) step();
        push(cyc, S_TX, 128'(0), "rst_tx");
        push(cyc, S_LOCK, 128'(0), "rst_lock");
        push(cyc, S_PULSE, 128'(0), "rst_pulse");
        push(cyc, S_CNT, 128'(0), "rst_cnt");
        push(cyc, S_BITS, 128'(0), "rst_bits");
        push(cyc, S_LOST, 128'(0), "rst_lost");

        // Loopback lock and 1000 clean cycles.
        RST_N = 1'b1; en = 1'b1; f = cyc;
        tx_base = f + 1;
        push(f + 1, S_TX, p(0), "first_tx_aa");
        push(f + 2, S_TX, p(1), "second_tx_55");
        push(f + 2, S_LOCK, 128'(0), "lock_early");
        push(f + 3, S_LOCK, 128'(1), "lock_rise");
        push(f + 3, S_LOCK2, 128'(1), "lock2_rise");
        repeat (1000) step();
        push(cyc, S_CNT, 128'(0), "loop_cnt");
        push(cyc, S_LOST, 128'(0), "loop_lost");
        push(cyc, S_LOCK, 128'(1), "loop_lock");
        push(cyc, S_TX, p(ph()), "loop_tx");

        // Single bit-70 error on a 55 word.
        wait_ph(1); f = cyc; inj[70] = 1'b1;
        push(f, S_TX, p(1), "tx_is_55");
        push(f + 1, S_PULSE, 128'(0), "b70_no_early_pulse");
        push(f + 2, S_PULSE, 128'(1), "b70_pulse");
        push(f + 3, S_PULSE, 128'(0), "b70_single_pulse");
        push(f + 2, S_CNT, 128'(1), "b70_cnt");
        push(f + 2, S_BITS, 128'(1) << 70, "b70_bits");
        push(f + 4, S_LOCK, 128'(1), "b70_lock");
        step(); inj = '0; repeat (4) step();

        // Four more isolated errors bring err_cnt to 5.
        for (int k = 0; k < 4; k++) begin
            f = cyc; inj[k] = 1'b1;
            push(f + 2, S_CNT, 128'(2 + k), "iso_cnt");
            step(); inj = '0; step(); step();
        end
        push(cyc, S_BITS, (128'(1) << 70) | 128'(15), "iso_bits");
        push(cyc, S_LOCK, 128'(1), "iso_lock");

        // clr in the same cycle as a mismatch.
        f = cyc; inj[5] = 1'b1;
        step(); inj = '0; clr = 1'b1;
        push(f + 1, S_CNT, 128'(5), "pre_clr_cnt");
        push(f + 2, S_PULSE, 128'(1), "clr_pulse_kept");
        push(f + 2, S_CNT, 128'(0), "clr_cnt");
        push(f + 2, S_BITS, 128'(0), "clr_bits");
        push(f + 2, S_LOCK, 128'(1), "clr_lock");
        step(); clr = 1'b0; step();
        push(cyc, S_CNT, 128'(0), "post_clr_cnt");

        // Saturation on the 3-bit counter instance: 12 isolated errors.
        for (int k = 1; k <= 12; k++) begin
            f = cyc; inj2 = 8'(1 << (k % 8));
            push(f + 2, S_CNT2, 128'((k > 7) ? 7 : k), "sat_cnt");
            push(f + 2, S_PULSE2, 128'(1), "sat_pulse");
            step(); inj2 = '0; step(); step();
        end
        push(cyc, S_LOCK2, 128'(1), "sat_lock");
        push(cyc, S_BITS2, 128'(8'hFF), "sat_bits");
        push(cyc, S_LOST2, 128'(0), "sat_lost");

        // rx_data forced to zero for 10 cycles while locked.
        wait_ph(1); f = cyc; force0 = 1'b1;
        push(f + 4, S_PULSE, 128'(1), "z_miss3");
        push(f + 5, S_PULSE, 128'(0), "z_00_match");
        push(f + 8, S_LOCK, 128'(1), "z_still_locked");
        push(f + 9, S_PULSE, 128'(1), "z_last_miss");
        push(f + 9, S_LOCK, 128'(0), "z_hunt");
        push(f + 9, S_LOST, 128'(1), "z_lost");
        push(f + 9, S_CNT, 128'(7), "z_cnt");
        push(f + 12, S_PULSE, 128'(0), "z_hunt_no_pulse");
        push(f + 14, S_LOCK, 128'(0), "z_relock_early");
        push(f + 15, S_LOCK, 128'(1), "z_relock");
        push(f + 20, S_CNT, 128'(7), "z_cnt_hold");
        repeat (10) step(); force0 = 1'b0; repeat (12) step();

        // en low for 5 cycles while tx_data shows F0.
        wait_ph(3); f = cyc; en = 1'b0;
        push(f, S_TX, p(3), "en_tx_f0");
        for (int d = 1; d <= 5; d++) push(f + d, S_TX, p(3), "en_hold_f0");
        repeat (5) step(); en = 1'b1;
        push(f + 6, S_TX, p(4), "en_resume_00");
        push(f + 7, S_TX, p(5), "en_resume_ff");
        tx_base = f + 2;
        repeat (40) step();
        push(cyc, S_LOCK, 128'(1), "stall_relock");
        push(cyc, S_LOST, 128'(2), "stall_lost");
        push(cyc, S_CNT, 128'(11), "stall_cnt");
        step();

        // Reset for one edge while locked.
        RST_N = 1'b0; step();
        push(cyc, S_TX, 128'(0), "mid_rst_tx");
        push(cyc, S_LOCK, 128'(0), "mid_rst_lock");
        push(cyc, S_PULSE, 128'(0), "mid_rst_pulse");
        push(cyc, S_CNT, 128'(0), "mid_rst_cnt");
        push(cyc, S_BITS, 128'(0), "mid_rst_bits");
        push(cyc, S_LOST, 128'(0), "mid_rst_lost");
        RST_N = 1'b1; f = cyc;
        push(f + 1, S_TX, p(0), "rst_tx_aa");
        push(f + 2, S_LOCK, 128'(0), "rst_lock_early");
        push(f + 3, S_LOCK, 128'(1), "rst_relock");
        repeat (6) step();

        // Direct end-of-run checks after the mid-run reset and re-lock.
        check({127'd0, locked},    128'(1), "end_locked");
        check({127'd0, err_pulse}, 128'(0), "end_pulse");
        check({112'd0, err_cnt},   128'(0), "end_cnt");
        check({57'd0, err_bits},   128'(0), "end_bits");
        check({120'd0, lost_cnt},  128'(0), "end_lost");
        check({127'd0, lock2},     128'(1), "end_lock2");
        check({125'd0, cnt2},      128'(0), "end_cnt2");
        check({120'd0, lost2},     128'(0), "end_lost2");
        check({120'd0, bits2},     128'(0), "end_bits2");

        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL unchecked_%s due=%0d", exp_q[0].name, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
